watch_mode_sequencer: RTL

Central mode controller for the watch top level. It owns the mode state and routes debounced function-button pulses to exactly one of the watch, stop-watch or cook-timer modules. It selects that module's 16-bit value for the FND controller. It preempts the current mode when the cook timer raises an alarm, and returns to watch mode after a period of inactivity.

---
 rtl/watch_mode_sequencer_if.sv | 33 +++
 rtl/watch_mode_sequencer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/watch_mode_sequencer_if.sv
// Signal bundle between the watch top level and the mode sequencer:
// button/tick/alarm inputs, per-module values and busy levels, routed outputs.
interface watch_mode_sequencer_if;
    logic        tick_1s;
    logic        mode_pe;
    logic [2:0]  btn_pe;
    logic        alarm_req;
    logic [2:0]  busy;
    logic [15:0] value_watch;
    logic [15:0] value_stop_watch;
    logic [15:0] value_cook_timer;
    logic [2:0]  btn_watch;
    logic [2:0]  btn_stop_watch;
    logic [2:0]  btn_cook_timer;
    logic [15:0] value;
    logic [1:0]  mode;
    logic [7:0]  led_bar;
    logic        buzzer_en;

    modport master (
        output tick_1s, mode_pe, btn_pe, alarm_req, busy,
               value_watch, value_stop_watch, value_cook_timer,
        input  btn_watch, btn_stop_watch, btn_cook_timer,
               value, mode, led_bar, buzzer_en
    );

    modport slave (
        input  tick_1s, mode_pe, btn_pe, alarm_req, busy,
               value_watch, value_stop_watch, value_cook_timer,
        output btn_watch, btn_stop_watch, btn_cook_timer,
               value, mode, led_bar, buzzer_en
    );
endinterface

// File: rtl/watch_mode_sequencer.sv
// Watch mode controller: owns the mode FSM, routes button pulses to the selected
// module, preempts into an alarm state for the cook timer and times out idle modes.
module watch_mode_sequencer #(
    parameter int IDLE_SEC  = 30,
    parameter int ALARM_SEC = 10
) (
    input logic                   clk,
    input logic                   reset_p,
    watch_mode_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        WATCH = 2'b00,
        STOPW = 2'b01,
        COOK  = 2'b10,
        ALARM = 2'b11
    } state_e;

    localparam logic [5:0] IDLE_LIM  = 6'(IDLE_SEC);
    localparam logic [5:0] ALARM_LIM = 6'(ALARM_SEC);

    state_e      state_q, state_d;
    logic [1:0]  saved_mode_q, saved_mode_d;
    logic [5:0]  idle_cnt_q, idle_cnt_d;
    logic [5:0]  alarm_cnt_q, alarm_cnt_d;
    logic        blink_q, blink_d;
    logic [2:0]  route;
    logic [1:0]  cur_mode;
    logic        busy_cur;
    logic        any_press;

    logic [2:0]  btn_watch_q, btn_watch_d;
    logic [2:0]  btn_stop_watch_q, btn_stop_watch_d;
    logic [2:0]  btn_cook_timer_q, btn_cook_timer_d;
    logic [15:0] value_q, value_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  led_bar_q, led_bar_d;
    logic        buzzer_en_q, buzzer_en_d;

    function automatic logic [1:0] mode_of(state_e s);
        return (s == ALARM) ? 2'b10 : s;
    endfunction

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q      <= WATCH;
            saved_mode_q <= 2'b00;
            idle_cnt_q   <= '0;
            alarm_cnt_q  <= '0;
            blink_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            saved_mode_q <= saved_mode_d;
            idle_cnt_q   <= idle_cnt_d;
            alarm_cnt_q  <= alarm_cnt_d;
            blink_q      <= blink_d;
        end
    end

    // Priority: alarm_req, then acknowledge/alarm expiry, then mode_pe, then buttons/idle.
    always_comb begin
        state_d      = state_q;
        saved_mode_d = saved_mode_q;
        idle_cnt_d   = '0;
        alarm_cnt_d  = alarm_cnt_q;
        blink_d      = blink_q;
        route        = '0;
        cur_mode     = mode_of(state_q);
        any_press    = bus.mode_pe | (|bus.btn_pe);
        case (cur_mode)
            2'b01:   busy_cur = bus.busy[1];
            2'b10:   busy_cur = bus.busy[2];
            default: busy_cur = bus.busy[0];
        endcase

        if (bus.alarm_req) begin
            if (state_q != ALARM) begin
                saved_mode_d = cur_mode;
                blink_d      = 1'b1;
            end else if (bus.tick_1s) begin
                blink_d = ~blink_q;
            end
            state_d     = ALARM;
            alarm_cnt_d = '0;
        end else if (state_q == ALARM) begin
            if (any_press) begin
                state_d = state_e'(saved_mode_q);
            end else if (bus.tick_1s) begin
                alarm_cnt_d = alarm_cnt_q + 6'd1;
                blink_d     = ~blink_q;
                if (alarm_cnt_d == ALARM_LIM)
                    state_d = state_e'(saved_mode_q);
            end
        end else if (bus.mode_pe) begin
            case (state_q)
                WATCH:   state_d = STOPW;
                STOPW:   state_d = COOK;
                default: state_d = WATCH;
            endcase
        end else begin
            route = bus.btn_pe;
            if (state_q != WATCH && !(|bus.btn_pe) && !busy_cur) begin
                idle_cnt_d = idle_cnt_q + {5'd0, bus.tick_1s};
                if (idle_cnt_d == IDLE_LIM) begin
                    state_d    = WATCH;
                    idle_cnt_d = '0;
                end
            end
        end
    end

    // Mode-facing outputs follow the next state; value lags by one cycle on the current state.
    always_comb begin
        btn_watch_d      = (state_q == WATCH) ? route : 3'b000;
        btn_stop_watch_d = (state_q == STOPW) ? route : 3'b000;
        btn_cook_timer_d = (state_q == COOK)  ? route : 3'b000;
        mode_d           = mode_of(state_d);
        buzzer_en_d      = (state_d == ALARM);
        case (state_q)
            WATCH:   value_d = bus.value_watch;
            STOPW:   value_d = bus.value_stop_watch;
            default: value_d = bus.value_cook_timer;
        endcase
        case (state_d)
            WATCH:   led_bar_d = 8'b0000_0001;
            STOPW:   led_bar_d = 8'b0000_0010;
            COOK:    led_bar_d = 8'b0000_0100;
            default: led_bar_d = {blink_d, 4'b0000, blink_d, 2'b00};
        endcase
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            btn_watch_q      <= '0;
            btn_stop_watch_q <= '0;
            btn_cook_timer_q <= '0;
            value_q          <= '0;
            mode_q           <= 2'b00;
            led_bar_q        <= 8'b0000_0001;
            buzzer_en_q      <= 1'b0;
        end else begin
            btn_watch_q      <= btn_watch_d;
            btn_stop_watch_q <= btn_stop_watch_d;
            btn_cook_timer_q <= btn_cook_timer_d;
            value_q          <= value_d;
            mode_q           <= mode_d;
            led_bar_q        <= led_bar_d;
            buzzer_en_q      <= buzzer_en_d;
        end
    end

    assign bus.btn_watch      = btn_watch_q;
    assign bus.btn_stop_watch = btn_stop_watch_q;
    assign bus.btn_cook_timer = btn_cook_timer_q;
    assign bus.value          = value_q;
    assign bus.mode           = mode_q;
    assign bus.led_bar        = led_bar_q;
    assign bus.buzzer_en      = buzzer_en_q;
endmodule
